// File: rtl/dma_io_requester.sv
`default_nettype none
// ============================================================================
//  Module   : dma_io_requester
//  Purpose  : Single-channel I/O-device endpoint for an 8237A DMA controller.
//             Raises DREQ when the local FIFO can accept or supply a byte,
//             waits for DACK, and moves bytes across the system data bus on
//             IOR#/IOW# strobe ends. Honours EOP# and programmable polarities.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH        FIFO entries (power of two, >= 2)
//    THRESHOLD    request threshold in bytes (1..DEPTH)
//  Ports
//    Clock, Reset            system clock, synchronous active-high reset
//    SenseDreq, SenseDack    request / acknowledge polarity selects
//    Direction               0: device->memory (IOR#), 1: memory->device (IOW#)
//    DemandMode              0: single byte per request, 1: demand burst
//    Dreq / Dack             request out / acknowledge in
//    IorN, IowN, EopN        active-low bus strobes and terminal count
//    DbIn / DbOut / DbOe     system data bus in / out / drive enable
//    LocalWrEn/LocalWrData   device-side push
//    LocalRdEn/LocalRdData   device-side pop / FIFO head (0 when empty)
//    Count, Full, Empty      FIFO occupancy and status
//    Done                    one-cycle pulse after EOP#
//    Error                   sticky bus error (strobe on empty/full FIFO)
// ============================================================================
module dma_io_requester #(
   parameter int DEPTH     = 8,
   parameter int THRESHOLD = 1
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic                       SenseDreq,
   input  logic                       SenseDack,
   input  logic                       Direction,
   input  logic                       DemandMode,
   output logic                       Dreq,
   input  logic                       Dack,
   input  logic                       IorN,
   input  logic                       IowN,
   input  logic                       EopN,
   input  logic [7:0]                 DbIn,
   output logic [7:0]                 DbOut,
   output logic                       DbOe,
   input  logic                       LocalWrEn,
   input  logic [7:0]                 LocalWrData,
   input  logic                       LocalRdEn,
   output logic [7:0]                 LocalRdData,
   output logic [$clog2(DEPTH):0]     Count,
   output logic                       Full,
   output logic                       Empty,
   output logic                       Done,
   output logic                       Error
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] THR_C   = CW'(THRESHOLD);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_XFER    = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   logic [1:0]    state;
   logic [1:0]    state_nxt;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          empty;
   logic          full;
   logic [7:0]    head;

   logic          dir_lat;
   logic          demand_lat;
   logic          eff_dir;
   logic          eff_demand;

   logic          ack_active;
   logic          ack_q;
   logic          strobe;
   logic          strobe_q;
   logic          bus_end;
   logic          xfer_end;
   logic          eop_event;

   logic [7:0]    hold;
   logic          local_pop;
   logic          local_push;
   logic          dma_pop;
   logic          dma_push;
   logic          do_pop;
   logic          do_push;
   logic [7:0]    push_data;
   logic          err_set;

   logic          ready;
   logic          ready_nxt;
   logic          req_int;
   logic          done_q;
   logic          error_q;

   // ------------------------------------------------------------------------
   // Mode selection. Direction and DemandMode are followed live while idle and
   // frozen for the rest of a request/transfer sequence.
   // ------------------------------------------------------------------------
   assign eff_dir    = (state == S_IDLE) ? Direction  : dir_lat;
   assign eff_demand = (state == S_IDLE) ? DemandMode : demand_lat;

   assign ack_active = Dack ^ ~SenseDack;
   assign strobe     = eff_dir ? IowN : IorN;

   // A byte completes on the rising edge of the relevant strobe, with the
   // channel acknowledged on both samples. In RELEASE the controller still
   // owns the bus, so a stray strobe there is checked for errors but moves
   // no data.
   assign bus_end   = ((state == S_XFER) || (state == S_RELEASE)) &&
                      ack_q && ack_active && !strobe_q && strobe;
   assign xfer_end  = bus_end && (state == S_XFER);
   assign eop_event = (state == S_XFER) && !EopN && ack_active;

   // ------------------------------------------------------------------------
   // FIFO push / pop arbitration. One write port and one read port: a DMA
   // transfer takes the port in its direction, the local side shares the
   // other one. A push is allowed on a full FIFO when a pop happens in the
   // same cycle.
   // ------------------------------------------------------------------------
   assign empty      = (count == '0);
   assign full       = (count == DEPTH_C);
   assign head       = empty ? 8'h00 : mem[rd_ptr];

   assign dma_pop    = xfer_end && !eff_dir && !empty;
   assign local_pop  = LocalRdEn && !empty && !dma_pop;
   assign do_pop     = dma_pop || local_pop;

   assign dma_push   = xfer_end && eff_dir && (!full || local_pop);
   assign local_push = LocalWrEn && (!full || do_pop) && !dma_push;
   assign do_push    = dma_push || local_push;
   assign push_data  = dma_push ? hold : LocalWrData;

   assign err_set    = bus_end && (eff_dir ? (full && !local_pop) : empty);

   assign count_nxt  = count + CW'(do_push) - CW'(do_pop);

   assign ready     = eff_dir ? ((DEPTH_C - count) >= THR_C)     : (count >= THR_C);
   assign ready_nxt = eff_dir ? ((DEPTH_C - count_nxt) >= THR_C) : (count_nxt >= THR_C);

   // ------------------------------------------------------------------------
   // FIFO storage (contents are not reset; pointers and count are)
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Bus-side sampling, holding register, status flags
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         ack_q      <= 1'b0;
         strobe_q   <= 1'b1;
         hold       <= 8'h00;
         dir_lat    <= 1'b0;
         demand_lat <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         ack_q    <= ack_active;
         strobe_q <= strobe;
         // The last data-bus value seen while IOW# is low is the one pushed.
         if (!IowN) begin
            hold <= DbIn;
         end
         if (state == S_IDLE) begin
            dir_lat    <= Direction;
            demand_lat <= DemandMode;
         end
         done_q <= eop_event;
         if (err_set) begin
            error_q <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (ready) begin
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (ack_active) begin
               state_nxt = S_XFER;
            end else if (!ready) begin
               state_nxt = S_IDLE;
            end
         end
         S_XFER: begin
            if (eop_event) begin
               state_nxt = S_RELEASE;
            end else if (xfer_end) begin
               // Demand mode keeps the request while the post-transfer
               // occupancy still satisfies the threshold.
               if (eff_demand && ready_nxt) begin
                  state_nxt = S_XFER;
               end else begin
                  state_nxt = S_RELEASE;
               end
            end else if (!ack_active) begin
               state_nxt = ready ? S_REQ : S_IDLE;
            end
         end
         S_RELEASE: begin
            if (!ack_active) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      req_int = (state == S_REQ) || (state == S_XFER);
      DbOe    = ack_active && !IorN && (state == S_XFER) && !eff_dir;
   end

   assign Dreq        = req_int ^ SenseDreq;
   assign DbOut       = eff_dir ? 8'h00 : head;
   assign LocalRdData = head;
   assign Count       = count;
   assign Full        = full;
   assign Empty       = empty;
   assign Done        = done_q;
   assign Error       = error_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_io_requester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_io_requester
//  Purpose  : Directed self-checking bench for dma_io_requester
//             (DEPTH=8, THRESHOLD=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dma_io_requester;

   logic       clk = 1'b0;
   logic       rst;
   logic       sense_dreq, sense_dack, direction, demand_mode;
   logic       dreq, dack, ior_n, iow_n, eop_n;
   logic [7:0] db_in, db_out;
   logic       db_oe;
   logic       wr_en, rd_en;
   logic [7:0] wr_data, rd_data;
   logic [3:0] count;
   logic       full, empty, done, error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dma_io_requester #(.DEPTH(8), .THRESHOLD(1)) dut (
      .Clock(clk), .Reset(rst),
      .SenseDreq(sense_dreq), .SenseDack(sense_dack),
      .Direction(direction), .DemandMode(demand_mode),
      .Dreq(dreq), .Dack(dack),
      .IorN(ior_n), .IowN(iow_n), .EopN(eop_n),
      .DbIn(db_in), .DbOut(db_out), .DbOe(db_oe),
      .LocalWrEn(wr_en), .LocalWrData(wr_data),
      .LocalRdEn(rd_en), .LocalRdData(rd_data),
      .Count(count), .Full(full), .Empty(empty),
      .Done(done), .Error(error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input logic sdreq, input logic sdack);
      sense_dreq = sdreq; sense_dack = sdack;
      dack = ~sdack;           // inactive level
      ior_n = 1'b1; iow_n = 1'b1; eop_n = 1'b1;
      wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00; db_in = 8'h00;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      wr_en = 1'b1; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   initial begin
      direction = 1'b0; demand_mode = 1'b0;

      // ---------------- reset state + single mode, Direction 0 -------------
      do_reset(1'b0, 1'b0);
      chk("rst_dreq",  dreq, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full",  full, 0);
      chk("rst_rdata", rd_data, 0);
      chk("rst_dboe",  db_oe, 0);
      chk("rst_dbout", db_out, 0);
      chk("rst_done",  done, 0);
      chk("rst_error", error, 0);

      push(8'hA5);
      chk("t1_count1", count, 1);
      chk("t1_dreq_lat", dreq, 0);
      tick();
      chk("t1_dreq_on", dreq, 1);
      dack = 1'b0;
      tick();                                   // XFER
      ior_n = 1'b0; #1;
      chk("t1_dboe", db_oe, 1);
      chk("t1_dbout", db_out, 8'hA5);
      tick();
      tick();
      ior_n = 1'b1;
      tick();                                   // strobe end
      chk("t1_dreq_off", dreq, 0);
      chk("t1_count0", count, 0);
      chk("t1_dboe_off", db_oe, 0);
      dack = 1'b1;
      tick();
      tick();
      chk("t1_idle_dreq", dreq, 0);

      // ---------------- demand mode, Direction 1, fill FIFO ----------------
      direction = 1'b1; demand_mode = 1'b1;
      do_reset(1'b0, 1'b0);
      tick();
      chk("t2_dreq_on", dreq, 1);
      dack = 1'b0;
      tick();
      for (int i = 1; i <= 8; i++) begin
         db_in = 8'(i); iow_n = 1'b0;
         tick();
         iow_n = 1'b1;
         tick();
         chk("t2_count", count, i);
         chk("t2_dreq", dreq, (i < 8) ? 1 : 0);
      end
      chk("t2_full", full, 1);
      dack = 1'b1;
      tick();
      for (int i = 1; i <= 8; i++) begin
         chk("t2_pop", rd_data, i);
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
      end
      chk("t2_empty", empty, 1);
      chk("t2_err", error, 0);

      // ---------------- EOP mid-burst, demand, Direction 0 -----------------
      direction = 1'b0; demand_mode = 1'b1;
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
      chk("t3_count4", count, 4);
      chk("t3_dreq", dreq, 1);
      dack = 1'b0;
      tick();
      ior_n = 1'b0; tick();
      ior_n = 1'b1; tick();
      chk("t3_count3", count, 3);
      chk("t3_dreq_hold", dreq, 1);
      ior_n = 1'b0; #1;
      chk("t3_dbout", db_out, 8'h11);
      tick();
      ior_n = 1'b1; eop_n = 1'b0;
      tick();
      chk("t3_done", done, 1);
      chk("t3_count2", count, 2);
      chk("t3_dreq_off", dreq, 0);
      eop_n = 1'b1;
      tick();
      chk("t3_done_pulse", done, 0);
      chk("t3_count_hold", count, 2);

      // ---------------- inverted polarities -------------------------------
      direction = 1'b0; demand_mode = 1'b0;
      do_reset(1'b1, 1'b1);                      // dack=0 is inactive
      chk("t4_dreq_idle", dreq, 1);
      push(8'h5A);
      tick();
      chk("t4_dreq_on", dreq, 0);
      ior_n = 1'b0; #1;
      chk("t4_dboe_noack", db_oe, 0);
      tick();
      ior_n = 1'b1; tick();
      chk("t4_count_noack", count, 1);
      chk("t4_dreq_still", dreq, 0);
      dack = 1'b1;
      tick();
      ior_n = 1'b0; #1;
      chk("t4_dboe", db_oe, 1);
      chk("t4_dbout", db_out, 8'h5A);
      tick();
      ior_n = 1'b1; tick();
      chk("t4_count0", count, 0);
      chk("t4_dreq_off", dreq, 1);
      dack = 1'b0;
      tick();

      // ---------------- error: strobe on empty FIFO -----------------------
      direction = 1'b0; demand_mode = 1'b1;
      do_reset(1'b0, 1'b0);
      push(8'h77);
      tick();
      dack = 1'b0;
      tick();
      ior_n = 1'b0; tick();
      ior_n = 1'b1; tick();
      chk("t5_count0", count, 0);
      chk("t5_err_pre", error, 0);
      ior_n = 1'b0; #1;
      chk("t5_dbout0", db_out, 8'h00);
      tick();
      ior_n = 1'b1; tick();
      chk("t5_err", error, 1);
      chk("t5_count", count, 0);
      dack = 1'b1;
      tick();
      tick();
      chk("t5_err_sticky", error, 1);

      // ---------------- reset mid-transfer --------------------------------
      direction = 1'b0; demand_mode = 1'b0;
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
      dack = 1'b0;
      tick();                                    // XFER
      ior_n = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("t6_dreq", dreq, 0);
      chk("t6_count", count, 0);
      chk("t6_empty", empty, 1);
      chk("t6_dboe", db_oe, 0);
      chk("t6_done", done, 0);
      rst = 1'b0;
      ior_n = 1'b1; dack = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dma_io_requester.md
# dma_io_requester

Single-channel I/O-device endpoint for the 8237A DMA controller. It raises DREQ toward the controller's channel arbiter, waits for DACK, and moves bytes across the system data bus on IOR#/IOW# strobes to or from a local DEPTH-entry FIFO. It honours EOP# and the controller's programmable DREQ/DACK polarities. The bench instantiates one per channel as the device-side counterpart of the priority encoder and transfer engine; it is also the device-side RTL for integration.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- THRESHOLD, 1, request threshold in bytes (1..DEPTH)
- Clock  in  1  system clock; all logic on posedge
- Reset  in  1  synchronous, active-high
- SenseDreq  in  1  0: Dreq active high; 1: Dreq active low (matches Command[6])
- SenseDack  in  1  0: Dack active low; 1: Dack active high (matches Command[7])
- Direction  in  1  0: device→memory (IOR# cycles); 1: memory→device (IOW# cycles)
- DemandMode  in  1  0: single (one byte per request); 1: demand (hold Dreq while able)
- Dreq  out  1  registered request, polarity applied
- Dack  in  1  acknowledge for this channel, polarity per SenseDack
- IorN, IowN  in  1 each  active-low I/O strobes
- EopN  in  1  active-low terminal count
- DbIn  in  8  data bus input
- DbOut  out  8  data bus output
- DbOe  out  1  data bus drive enable
- LocalWrEn, LocalWrData  in  1, 8  device-side push
- LocalRdEn  in  1  device-side pop
- LocalRdData  out  8  FIFO head; 0 when empty
- Count  out  $clog2(DEPTH)+1  FIFO occupancy
- Full, Empty  out  1 each  FIFO status
- Done  out  1  one-cycle pulse on EOP
- Error  out  1  sticky: read strobe on empty FIFO or write strobe on full FIFO

## Operation
- AckActive = Dack ^ ~SenseDack. Dreq = ReqInt ^ SenseDreq.
- Ready = (Direction==0) ? Count ≥ THRESHOLD : (DEPTH − Count) ≥ THRESHOLD.
- FSM states: IDLE, REQ, XFER, RELEASE. ReqInt=1 in REQ and XFER only.
  - IDLE → REQ when Ready.
  - REQ → XFER when AckActive. REQ → IDLE when Ready drops (device popped/pushed).
  - XFER: a byte completes on strobe end, i.e. the strobe was sampled low last cycle and is sampled high now, with AckActive both cycles. Only IorN counts when Direction=0; only IowN when Direction=1.
    - After a byte: single mode → RELEASE. Demand mode → stay in XFER if Ready (post-update count), else RELEASE.
  - XFER with EopN sampled low and AckActive → Done=1 for one cycle, → RELEASE. A byte ending in the same cycle still completes.
  - XFER with AckActive dropped and no strobe end → REQ if Ready, else IDLE.
  - RELEASE → IDLE when AckActive is low.
- Direction 0: DbOe = AckActive & ~IorN & XFER. DbOut = FIFO head. Pop at strobe end.
- Direction 1: DbIn is captured into a holding register each cycle IowN is low. The holding register is pushed at strobe end.
- Error conditions:
  - Strobe end with Direction 0 and the FIFO empty: no pop, DbOut=0x00, Error set.
  - Strobe end with Direction 1 and the FIFO full: byte dropped, Error set.
- FIFO rules:
  - Pointers wrap modulo DEPTH.
  - Local push when Full and local pop when Empty are ignored.
  - A local push and a DMA pop in the same cycle, or a DMA push and a local pop in the same cycle, leave Count unchanged.
  - A push and a pop on a full FIFO are both legal.
- Direction and DemandMode changes take effect only in IDLE. They are sampled every cycle, and changing them outside IDLE is a usage error.

## Timing
- Reset values:
  - State IDLE; Dreq = SenseDreq (inactive level).
  - DbOe=0, DbOut=0, Done=0, Error=0.
  - Count=0, Empty=1, Full=0, LocalRdData=0.
  - FIFO contents discarded.
- Reset mid-transfer aborts immediately, with no Done and no partial push.
- Ready true at cycle N in IDLE → Dreq active at cycle N+1.
- AckActive sampled at cycle N in REQ → XFER at N+1.
- Strobe rising at cycle N → Count updated at N+1.
  - Single mode: Dreq inactive at N+1.
  - Demand mode: Dreq inactive at N+1 only if Ready is false.
- EopN low at cycle N → Done high during N+1, Dreq inactive at N+1.
- DbOe and DbOut are combinational from the strobe and the FIFO head; there is no cycle of latency.
- Minimum strobe low width is one clock.

## Test plan
- Single mode, Direction 0, polarities 0/0, THRESHOLD=1: push 0xA5 → Dreq=1 next cycle. Dack=0 → XFER. IorN low 2 cycles → DbOe=1, DbOut=0xA5. Then Dreq=0, Count=0; Dack=1 → IDLE.
- Demand mode, Direction 1, DEPTH=8: 8 IOW# strobes with 0x01..0x08 → Dreq stays active until Count=8, drops the cycle after the 8th. Local pops return 0x01..0x08 in order.
- EOP mid-burst: demand mode, Direction 0, 4 bytes queued, EopN low with the 2nd strobe end → Done pulse, Count=2, Dreq inactive, no further pops.
- Polarity: SenseDreq=1, SenseDack=1 → Dreq idles high, asserts low; transfer proceeds only with Dack=1; Dack=0 ignored.
- Error: Direction 0, Count=1, demand mode, two IOR# strobes → second strobe gives DbOut=0x00, Error=1 sticky, Count stays 0.
- Reset with Dack active in XFER and 3 bytes queued → next cycle Dreq inactive, Count=0, Empty=1, DbOe=0, Done=0.
